classify_arbiter: RTL and testbench
===================================

# classify_arbiter

Shares one odd/even classification engine between NREQ requesters. Each requester offers an 8-bit number over a valid/ready handshake. The block grants one requester at a time (round-robin) and classifies the number as odd or even. It then computes the true remainder: number mod 3 when odd, number mod 4 when even. The result is returned on a single response channel tagged with the requester index. It sits between the project's number sources and any consumer of parity/remainder results.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  requester i has a number pending.
- req_number  input  8*NREQ  bits [8i+7:8i] are requester i's number; must be stable while req_valid[i] is high.
- req_ready  output  NREQ  one-hot grant; handshake for i occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  3  index of the requester that owns the response.
- rsp_odd  output  1  1 if the number is odd, 0 if even.
- rsp_rem  output  8  number mod 3 if odd, number mod 4 if even.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, DIVIDE, RESP.
- **IDLE**
  - req_ready is combinational: one-hot on the first asserted req_valid at or after rr_ptr, searching upward with wrap at NREQ.
  - req_ready is all-zero when no req_valid is high, and in every other state.
  - On a handshake: latch the number and id, then go to LOAD.
- **LOAD**
  - odd = number[0].
  - If even: rem = {6'b0, number[1:0]}, go to RESP.
  - If odd: rem = number; go to RESP if rem < 3, else go to DIVIDE.
- **DIVIDE**
  - Each cycle: rem <= rem - 3.
  - Leave for RESP on the cycle the new value is < 3.
  - All arithmetic is 8-bit unsigned and rem never underflows.
- **RESP**
  - rsp_valid = 1; rsp_id, rsp_odd and rsp_rem are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: rr_ptr <= (rsp_id + 1) mod NREQ, go to IDLE.
- Zero is a valid job: even, rem 0. (Zero is not ignored.)
- Only one job is in flight; further requesters wait with req_valid high.
- A requester dropping req_valid before its grant is legal and is simply skipped.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_odd = 0, rsp_rem = 0.
  - busy = 0, req_ready = 0.
- Latency:
  - Request handshake in cycle T; LOAD in T+1.
  - k = floor(n/3) DIVIDE cycles when the number is odd; k = 0 when even.
  - rsp_valid first high in cycle T+2+k (even: T+2; n=255: T+87).
- rsp_valid and all rsp_* outputs are registered; rsp_ready is sampled only in RESP.
- The response handshake in cycle R returns to IDLE in R+1, so the next grant can occur in R+1.
- Simultaneous requests: exactly one grant per IDLE cycle, chosen by rr_ptr.
- Reset mid-operation (any state):
  - The in-flight job is discarded with no response issued.
  - Outputs and rr_ptr return to their reset values on the next edge.
- rsp_ready high while not in RESP has no effect.

## Configuration
- CLASSIFY_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest-index asserted req_valid always wins, and rr_ptr is not implemented.
  - Undefined (default): round-robin arbitration as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single job: requester 2 sends 8'd10 with rsp_ready tied high -> rsp_valid at T+2, rsp_id=2, rsp_odd=0, rsp_rem=2.
- Odd latency: requester 0 sends 8'd255 -> rsp_valid at T+87, rsp_odd=1, rsp_rem=0; then 8'd7 -> rsp_valid at T+4, rsp_rem=1.
- Edge values:
  - 8'd0 -> odd=0, rem=0 at T+2.
  - 8'd1 -> odd=1, rem=1 at T+2.
  - 8'd3 -> odd=1, rem=0 at T+3.
- Round-robin: all four req_valid held high with numbers 4, 5, 6, 7 -> grants in order 0, 1, 2, 3, 0.
  - With CLASSIFY_ARB_FIXED_PRIO_EN defined -> grants 0, 0, 0.
- Backpressure: rsp_ready held low 20 cycles after rsp_valid rises -> rsp_* outputs stable and req_ready all-zero throughout; the next grant occurs the cycle after rsp_ready rises.
- Reset mid-DIVIDE: rst asserted 10 cycles into an 8'd201 job -> the next cycle shows IDLE, busy=0, rsp_valid=0, and no response for that job ever appears.

Source files
------------

// File: rtl/classify_arbiter_if.sv
// Request/response bundle between NREQ number sources, the shared classifier and its consumer.
// The master modport is the requester/consumer side; slave is the arbiter itself.
interface classify_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_number;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic              rsp_odd;
    logic [7:0]        rsp_rem;

    modport master (
        output req_valid, req_number, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_odd, rsp_rem
    );

    modport slave (
        input  req_valid, req_number, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_odd, rsp_rem
    );
endinterface

// File: rtl/classify_arbiter.sv
// Round-robin arbiter sharing one odd/even classifier (mod 3 if odd, mod 4 if even) among NREQ requesters.
// Define CLASSIFY_ARB_FIXED_PRIO_EN to replace round-robin with lowest-index-wins fixed priority.
module classify_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    classify_arbiter_if.slave bus,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DIVIDE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      rem_q, rem_d;
    logic [2:0]      id_q, id_d;
    logic            odd_q, odd_d;
    logic            valid_q, valid_d;
    logic [NREQ-1:0] grant_s;
    logic [2:0]      gnt_id_s;
    logic [7:0]      gnt_num_s;
    logic            gnt_found_s;
    logic [2:0]      base_s;

`ifdef CLASSIFY_ARB_FIXED_PRIO_EN
    assign base_s = 3'd0;
`else
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    assign base_s = rr_ptr_q;
`endif

    // Rotating priority search: first pass covers indices at/after base, second pass wraps below it.
    always_comb begin
        grant_s     = '0;
        gnt_id_s    = 3'd0;
        gnt_num_s   = 8'd0;
        gnt_found_s = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found_s && bus.req_valid[i] && (i >= int'(base_s))) begin
                gnt_found_s = 1'b1;
                grant_s[i]  = 1'b1;
                gnt_id_s    = 3'(i);
                gnt_num_s   = bus.req_number[8*i +: 8];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found_s && bus.req_valid[i]) begin
                gnt_found_s = 1'b1;
                grant_s[i]  = 1'b1;
                gnt_id_s    = 3'(i);
                gnt_num_s   = bus.req_number[8*i +: 8];
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Next-state and datapath: the remainder register doubles as the latched number.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        id_d     = id_q;
        odd_d    = odd_q;
        valid_d  = valid_q;
`ifndef CLASSIFY_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_found_s) begin
                    rem_d   = gnt_num_s;
                    id_d    = gnt_id_s;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                odd_d = rem_q[0];
                if (!rem_q[0]) begin
                    rem_d   = {6'd0, rem_q[1:0]};
                    state_d = RESP;
                    valid_d = 1'b1;
                end else if (rem_q < 8'd3) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                end else begin
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = rem_q - 8'd3;
                if (rem_d < 8'd3) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                end else begin
                    state_d = DIVIDE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    valid_d  = 1'b0;
                    state_d  = IDLE;
`ifndef CLASSIFY_ARB_FIXED_PRIO_EN
                    rr_ptr_d = 3'((int'(id_q) + 1) % NREQ);
`endif
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers; reset discards any in-flight job.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= 8'd0;
            id_q     <= 3'd0;
            odd_q    <= 1'b0;
            valid_q  <= 1'b0;
`ifndef CLASSIFY_ARB_FIXED_PRIO_EN
            rr_ptr_q <= 3'd0;
`endif
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            id_q     <= id_d;
            odd_q    <= odd_d;
            valid_q  <= valid_d;
`ifndef CLASSIFY_ARB_FIXED_PRIO_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE) ? grant_s : '0;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_odd   = odd_q;
    assign bus.rsp_rem   = rem_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_classify_arbiter.sv
// Randomised + directed bench for classify_arbiter with a queue-based scoreboard and
// an arithmetic reference model of arbitration order, remainder and response latency.
module tb_classify_arbiter;
    localparam int NREQ = 4;
`ifdef CLASSIFY_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    classify_arbiter_if #(.NREQ(NREQ)) bus ();

    classify_arbiter #(.NREQ(NREQ)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int odd;
        int rem;
        int due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ptr_m = 0;
    bit   busy_m = 1'b0;
    bit   seen_m = 1'b0;
    bit   rst_prev = 1'b1;
    bit   end_req = 1'b0;
    bit   end_done = 1'b0;
    int   g;
    int   n;
    exp_t it;
    exp_t nx;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int exp_grant(logic [NREQ-1:0] v, int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst_prev) begin
            chk("reset_rsp_id", int'(bus.rsp_id), 0);
            chk("reset_rsp_odd", int'(bus.rsp_odd), 0);
            chk("reset_rsp_rem", int'(bus.rsp_rem), 0);
        end
        chk("busy", int'(busy), int'(busy_m));
        g = (busy_m || bus.req_valid == '0) ? -1 : exp_grant(bus.req_valid, FIXED ? 0 : ptr_m);
        chk("req_ready", int'(bus.req_ready), (g < 0) ? 0 : (1 << g));
        if (sb.size() > 0) begin
            it = sb[0];
            if (cyc == it.due) chk("rsp_valid_at_due", int'(bus.rsp_valid), 1);
            if (bus.rsp_valid) begin
                chk("rsp_id", int'(bus.rsp_id), it.id);
                chk("rsp_odd", int'(bus.rsp_odd), it.odd);
                chk("rsp_rem", int'(bus.rsp_rem), it.rem);
                if (!seen_m) begin
                    chk("rsp_latency", cyc, it.due);
                    seen_m = 1'b1;
                end
                if (bus.rsp_ready) begin
                    void'(sb.pop_front());
                    busy_m = 1'b0;
                    seen_m = 1'b0;
                    ptr_m  = (it.id + 1) % NREQ;
                end
            end
        end else begin
            chk("rsp_valid_no_job", int'(bus.rsp_valid), 0);
        end
        if (g >= 0) begin
            n      = int'(8'(bus.req_number >> (8 * g)));
            nx.id  = g;
            nx.odd = n % 2;
            nx.rem = (n % 2 == 1) ? n % 3 : n % 4;
            nx.due = cyc + 2 + ((n % 2 == 1) ? n / 3 : 0);
            sb.push_back(nx);
            busy_m = 1'b1;
        end
        if (end_req && !end_done) begin
            chk("scoreboard_drained", sb.size(), 0);
            end_done = 1'b1;
        end
        if (rst) begin
            sb.delete();
            busy_m = 1'b0;
            seen_m = 1'b0;
            ptr_m  = 0;
        end
        rst_prev = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(int id, logic [7:0] num);
        bus.req_valid[id]         = 1'b1;
        bus.req_number[8*id +: 8] = num;
    endtask

    task automatic wait_grant(int id);
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.req_valid[id] && bus.req_ready[id]) break;
        end
        step();
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) break;
        end
        step();
    endtask

    task automatic send(int id, logic [7:0] num);
        put(id, num);
        wait_grant(id);
        wait_idle();
    endtask

    function automatic logic [7:0] rnd_num();
        case ($urandom_range(0, 3))
            0: return 8'($urandom_range(0, 7));
            1: return ($urandom_range(0, 1) == 0) ? 8'd255 : 8'd254;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Stimulus
    initial begin
        int cnt;
        logic [NREQ-1:0] hs;
        bus.req_valid  = '0;
        bus.req_number = '0;
        bus.rsp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        send(2, 8'd10);
        send(0, 8'd255);
        send(0, 8'd7);
        send(1, 8'd0);
        send(1, 8'd1);
        send(1, 8'd3);

        rst = 1'b1;
        step();
        rst = 1'b0;
        put(0, 8'd4);
        put(1, 8'd5);
        put(2, 8'd6);
        put(3, 8'd7);
        cnt = 0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if ((bus.req_valid & bus.req_ready) != '0) cnt++;
            if (cnt == 5) break;
        end
        step();
        bus.req_valid = '0;
        wait_idle();

        bus.rsp_ready = 1'b0;
        put(3, 8'd8);
        wait_grant(3);
        put(1, 8'd6);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        repeat (20) step();
        bus.rsp_ready = 1'b1;
        wait_grant(1);
        wait_idle();

        put(0, 8'd201);
        wait_grant(0);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (100) step();

        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (hs[i]) begin
                    bus.req_valid[i]        = 1'($urandom_range(0, 1));
                    bus.req_number[8*i +: 8] = rnd_num();
                end else if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) put(i, rnd_num());
                end else if ($urandom_range(0, 15) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end

        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        wait_idle();
        end_req = 1'b1;
        for (int t = 0; t < 10; t++) begin
            step();
            if (end_done) break;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
